exp2_lut_pipe: RTL and testbench
================================

// Module: exp2_lut_pipe
// PURPOSE
//  Fixed-point antilog unit: y = 2^x. Inverse of the log2 LUT path. Maps log2-domain
//  cepstral/spectral values back to linear magnitude. Fraction of x indexes a 2^(i/DEPTH)
//  LUT with linear interpolation; integer part of x is applied as a barrel shift.
//  3-stage pipeline, valid/ready on both sides, 1 sample/cycle when not stalled.
// PARAMETERS
//  WIDTH  16  bit width of in_x (signed) and out_y (unsigned)
//  BP     8   binary point: fractional bits of in_x and out_y; BP >= $clog2(DEPTH)+1
//  DEPTH  32  LUT segments per octave (power of 2); LUT holds DEPTH+1 entries
// PORTS
//  clock      in   1      rising-edge clock
//  reset_n    in   1      asynchronous active-low reset
//  in_valid   in   1      in_x is valid
//  in_ready   out  1      unit accepts in_x this cycle
//  in_x       in   WIDTH  signed two's complement, BP fractional bits (log2 value)
//  out_valid  out  1      out_y is valid
//  out_ready  in   1      downstream accepts out_y this cycle
//  out_y      out  WIDTH  unsigned, BP fractional bits, 2^in_x
// BEHAVIOUR
//  Reset (async assert, sync release): all stage valids=0, out_valid=0, out_y=0;
//   in-flight samples are discarded.
//  LUT: m[i] = round(2^(i/DEPTH) * 2^BP), i=0..DEPTH; m[0]=2^BP, m[DEPTH]=2^(BP+1).
//   Entries are BP+2 bits wide, built at elaboration, read-only.
//  Decomposition, with L = $clog2(DEPTH) and R = BP-L:
//   n = in_x >>> BP (floor, signed); f = in_x[BP-1:0];
//   idx = f[BP-1:R]; rem = f[R-1:0].
//  S1: register n, rem, m[idx], m[idx+1].
//  S2: mant = m[idx] + (((m[idx+1]-m[idx]) * rem) >> R); truncate, no rounding.
//   The difference is always >= 0. mant is BP+2 bits.
//  S3: if n >= WIDTH-BP, y = {WIDTH{1'b1}} (saturate).
//   Else if n >= 0, y = mant << n.
//   Else if -n > BP+1, y = 0 (underflow).
//   Else y = mant >> -n (truncate).
//   Any y >= 2^WIDTH after the shift also saturates to all-ones.
//  Latency: 3 cycles from the in_valid&&in_ready edge to out_valid, with no stall.
//  Handshake:
//   - A stage advances when its successor is empty or advancing.
//   - Final stage advances when out_ready or !out_valid.
//   - in_ready = !s1_valid || s1_advance, so a full pipe with out_ready=0 gives in_ready=0.
//   - out_y and out_valid stay stable while out_valid && !out_ready.
//   - Accept and emit in the same cycle are allowed; no bubbles at steady state.
//  Sentinel: the log2(0) code (-100<<BP, truncated) underflows to out_y=0.
//  Ordering: strict FIFO. Nothing is dropped and nothing is duplicated.
// TESTING
//  1. x=0x0000 -> y=0x0100 (1.0); x=0x0100 -> y=0x0200; x=0xFF00 -> y=0x0080. Each 3 cycles after accept.
//  2. x=0x0080 (0.5) -> y=0x016A (m[16]=362); x=0x0700 -> y=0x8000.
//  3. Saturation: x=0x0800 and x=0x7FFF -> y=0xFFFF. Underflow: x=0x9C00 and x=0x8000 -> y=0x0000.
//  4. Stream 100 back-to-back inputs with out_ready=1 -> in_ready stays 1;
//     100 outputs, in order, match the reference model.
//  5. Hold out_ready=0 -> after 3 accepts, in_ready=0 and out_y is held.
//     Random out_ready toggling -> no loss, duplication or reordering.
//  6. Assert reset_n=0 mid-stream with 3 in flight -> out_valid=0 and out_y=0 immediately.
//     After release, the first new sample returns correctly at latency 3.

Source files
------------

// File: rtl/exp2_lut_pipe_if.sv
// Streaming handshake bundle for the exp2 antilog unit: one input channel
// carrying the signed log2 value and one output channel carrying 2^x.
interface exp2_lut_pipe_if #(
    parameter int WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_x;
    logic                    out_valid;
    logic                    out_ready;
    logic        [WIDTH-1:0] out_y;

    // Producer/consumer side (the environment around the unit)
    modport master (
        output in_valid,
        output in_x,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_y
    );

    // The antilog unit itself
    modport slave (
        input  in_valid,
        input  in_x,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_y
    );
endinterface

// File: rtl/exp2_lut_pipe.sv
// Fixed-point antilog y = 2^x. The fractional part of x picks a segment of a
// 2^(i/DEPTH) table and is linearly interpolated; the integer part becomes a
// barrel shift with saturation on overflow and flush-to-zero on underflow.
// Three register stages with valid/ready back-pressure, one sample per cycle.
module exp2_lut_pipe #(
    parameter int WIDTH = 16,
    parameter int BP    = 8,
    parameter int DEPTH = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    exp2_lut_pipe_if.slave bus
);
    localparam int L  = $clog2(DEPTH);
    localparam int R  = BP - L;
    localparam int MW = BP + 2;
    localparam int NW = WIDTH - BP;

    // Mantissa table m[i] = round(2^(i/DEPTH) * 2^BP), fixed at elaboration
    logic [MW-1:0] lut [0:DEPTH];

    for (genvar i = 0; i <= DEPTH; i++) begin : g_lut
        localparam real MV = (2.0 ** (real'(i) / real'(DEPTH))) * (2.0 ** BP);
        assign lut[i] = MW'($rtoi(MV + 0.5));
    end

    // Linear interpolation between adjacent table entries, truncating.
    // Entries are monotonic so the difference never goes negative.
    function automatic logic [MW-1:0] interp(input logic [MW-1:0] mlo,
                                             input logic [MW-1:0] mhi,
                                             input logic [R-1:0]  rem);
        logic [MW-1:0]   diff;
        logic [MW+R-1:0] prod;
        diff = mhi - mlo;
        prod = (MW+R)'(diff) * (MW+R)'(rem);
        return mlo + MW'(prod >> R);
    endfunction

    // Apply the octave shift: saturate to all-ones when the result cannot
    // fit, flush to zero when the shift exceeds the mantissa width.
    function automatic logic [WIDTH-1:0] sat_shift(input logic [MW-1:0]        mant,
                                                   input logic signed [NW-1:0] n);
        int               ni;
        logic [WIDTH+1:0] wide;
        ni = int'(n);
        if (ni >= NW) begin
            return {WIDTH{1'b1}};
        end else if (ni >= 0) begin
            wide = (WIDTH+2)'(mant) << ni;
            if (|wide[WIDTH+1:WIDTH]) return {WIDTH{1'b1}};
            return wide[WIDTH-1:0];
        end else if (-ni > BP + 1) begin
            return '0;
        end
        return WIDTH'(mant >> (-ni));
    endfunction

    logic                 en_p0, en_p1, en_p2;
    logic                 vld_p0, vld_p1, vld_p2;
    logic [L:0]           idx_lo, idx_hi;

    logic signed [NW-1:0] n_p0;
    logic [R-1:0]         rem_p0;
    logic [MW-1:0]        mlo_p0, mhi_p0;

    logic signed [NW-1:0] n_p1;
    logic [MW-1:0]        mant_p1;

    logic [WIDTH-1:0]     y_p2;

    // A stage may load when it is empty or its contents move on this cycle
    assign en_p2 = !vld_p2 || bus.out_ready;
    assign en_p1 = !vld_p1 || en_p2;
    assign en_p0 = !vld_p0 || en_p1;

    assign bus.in_ready  = en_p0;
    assign bus.out_valid = vld_p2;
    assign bus.out_y     = y_p2;

    // Table addresses for the segment endpoints selected by the fraction
    always_comb begin
        idx_lo = {1'b0, bus.in_x[BP-1:R]};
        idx_hi = idx_lo + 1'b1;
    end

    // Pipeline occupancy and the output register; reset discards everything in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            y_p2   <= '0;
        end else begin
            if (en_p0) vld_p0 <= bus.in_valid;
            if (en_p1) vld_p1 <= vld_p0;
            if (en_p2) begin
                vld_p2 <= vld_p1;
                // ---- stage p2: octave shift and saturation ----
                if (vld_p1) y_p2 <= sat_shift(mant_p1, n_p1);
            end
        end
    end

    // Datapath registers for the first two stages; qualified only by the valids
    always_ff @(posedge clock) begin
        // ---- stage p0: decompose x and fetch both segment endpoints ----
        if (en_p0 && bus.in_valid) begin
            n_p0   <= bus.in_x[WIDTH-1:BP];
            rem_p0 <= bus.in_x[R-1:0];
            mlo_p0 <= lut[idx_lo];
            mhi_p0 <= lut[idx_hi];
        end
        // ---- stage p1: interpolate the mantissa ----
        if (en_p1 && vld_p0) begin
            n_p1    <= n_p0;
            mant_p1 <= interp(mlo_p0, mhi_p0, rem_p0);
        end
    end
endmodule

// File: tb/tb_exp2_lut_pipe.sv
// Directed bench for exp2_lut_pipe: known antilog points, saturation and
// underflow, a back-to-back stream, back-pressure, and reset mid-stream.
module tb_exp2_lut_pipe;
    logic clock;
    logic reset_n;

    exp2_lut_pipe_if #(.WIDTH(16)) ifc ();

    exp2_lut_pipe #(.WIDTH(16), .BP(8), .DEPTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    int          n_checks;
    int          n_fail;
    int          n_acc;
    int          n_recv;
    int          n_in_stall;
    int          m [0:32];
    logic [15:0] exp_q [$];

    logic [15:0] vx [0:8] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0080, 16'h0700,
                              16'h0800, 16'h7FFF, 16'h9C00, 16'h8000};
    logic [15:0] vy [0:8] = '{16'h0100, 16'h0200, 16'h0080, 16'h016A, 16'h8000,
                              16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: table interpolation, then shift with saturation/underflow
    function automatic logic [15:0] ref_y(input logic [15:0] x);
        int n, idx, rem, mant, v;
        n    = int'($signed(x)) >>> 8;
        idx  = int'(x[7:3]);
        rem  = int'(x[2:0]);
        mant = m[idx] + ((m[idx+1] - m[idx]) * rem) / 8;
        if (n >= 8) return 16'hFFFF;
        if (n >= 0) begin
            v = mant << n;
            if (v > 65535) return 16'hFFFF;
            return v[15:0];
        end
        if (n < -9) return 16'h0000;
        return 16'(mant >> (-n));
    endfunction

    // One clock cycle of stimulus from a negedge; scoreboard both handshakes
    task automatic cycle(input logic iv, input logic [15:0] x, input logic ordy);
        ifc.in_valid  = iv;
        ifc.in_x      = x;
        ifc.out_ready = ordy;
        #1;
        if (iv && !ifc.in_ready) n_in_stall++;
        if (iv && ifc.in_ready) begin
            exp_q.push_back(ref_y(x));
            n_acc++;
        end
        if (ifc.out_valid && ordy) begin
            n_recv++;
            if (exp_q.size() == 0) check("unexpected_out", 32'(ifc.out_valid), 32'd0);
            else                   check("stream_y", 32'(ifc.out_y), 32'(exp_q.pop_front()));
        end
        @(negedge clock);
    endtask

    // Single sample through an empty pipe with latency checks
    task automatic send_one(input logic [15:0] x, input logic [15:0] e);
        ifc.in_valid  = 1'b1;
        ifc.in_x      = x;
        ifc.out_ready = 1'b1;
        #1;
        check($sformatf("rdy_%h", x), 32'(ifc.in_ready), 32'd1);
        @(negedge clock);
        ifc.in_valid = 1'b0;
        #1;
        check($sformatf("lat1_%h", x), 32'(ifc.out_valid), 32'd0);
        @(negedge clock);
        #1;
        check($sformatf("lat2_%h", x), 32'(ifc.out_valid), 32'd0);
        @(negedge clock);
        #1;
        check($sformatf("lat3_%h", x), 32'(ifc.out_valid), 32'd1);
        check($sformatf("y_%h", x), 32'(ifc.out_y), 32'(e));
        @(negedge clock);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i <= 32; i++)
            m[i] = $rtoi((2.0 ** (real'(i) / 32.0)) * 256.0 + 0.5);

        reset_n       = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_x      = '0;
        ifc.out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_y", 32'(ifc.out_y), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Known points, saturation and underflow
        for (int i = 0; i < 9; i++) send_one(vx[i], vy[i]);

        // 100 back-to-back samples with the sink always ready
        n_acc = 0; n_recv = 0; n_in_stall = 0;
        for (int i = 0; i < 100; i++) cycle(1'b1, 16'(i * 311 + 16'hC800), 1'b1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, 16'h0000, 1'b1);
        check("t4_in_stalls", 32'(n_in_stall), 32'd0);
        check("t4_recv", 32'(n_recv), 32'd100);
        check("t4_left", 32'(exp_q.size()), 32'd0);

        // Sink stalled: three accepts fill the pipe and the output holds
        n_acc = 0; n_recv = 0;
        cycle(1'b1, 16'h0100, 1'b0);
        cycle(1'b1, 16'h0180, 1'b0);
        cycle(1'b1, 16'hFE40, 1'b0);
        ifc.in_valid = 1'b1;
        ifc.in_x     = 16'h0200;
        #1;
        check("hold_in_ready", 32'(ifc.in_ready), 32'd0);
        check("hold_valid", 32'(ifc.out_valid), 32'd1);
        check("hold_y0", 32'(ifc.out_y), 32'h0200);
        @(negedge clock);
        repeat (3) cycle(1'b1, 16'h0200, 1'b0);
        check("hold_y1", 32'(ifc.out_y), 32'h0200);
        check("hold_acc", 32'(n_acc), 32'd3);

        // Random sink readiness and sparse input: order and count preserved
        for (int c = 0; c < 2000 && n_recv < 43; c++)
            cycle((n_acc < 43) && ($urandom_range(0, 3) != 0),
                  16'(n_acc * 16'h0251 + 16'hF000),
                  1'($urandom_range(0, 1)));
        check("t5_recv", 32'(n_recv), 32'd43);
        check("t5_left", 32'(exp_q.size()), 32'd0);

        // Reset with three samples in flight
        cycle(1'b1, 16'h0100, 1'b0);
        cycle(1'b1, 16'h0300, 1'b0);
        cycle(1'b1, 16'h0000, 1'b0);
        ifc.in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(ifc.out_valid), 32'd0);
        check("midrst_y", 32'(ifc.out_y), 32'd0);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("postrst_valid", 32'(ifc.out_valid), 32'd0);
        @(negedge clock);
        send_one(16'h0100, 16'h0200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
